// File: rtl/uart_transmitter.sv
// uart_transmitter
//   Serializes bytes onto an idle-high 8N1 UART line: one start bit (0), eight
//   data bits LSB first, one stop bit (1). Each bit lasts SYMBOL_EDGE_TIME clk
//   cycles, so a whole frame is exactly 10*SYMBOL_EDGE_TIME cycles.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   asynchronous, active-high reset
//   data_in        in   byte to send, captured on the accepting edge
//   data_in_valid  in   source has a byte on data_in
//   data_in_ready  out  registered; high only while idle, a byte may be accepted
//   serial_out     out  registered TX line, idle high, forced high by reset
//
// Timing notes
//   The byte is accepted on an edge where data_in_valid && data_in_ready.
//   The start bit appears on serial_out right after that edge.
//   The final cycle of the stop bit is spent in IDLE with the line high and
//   ready raised. A source holding valid therefore has its next byte accepted
//   on the edge that ends the stop bit. Back-to-back frames are spaced exactly
//   10*SYMBOL_EDGE_TIME cycles apart, with no idle gap.
module uart_transmitter #(
  parameter int unsigned CLOCK_FREQ = 125_000_000,
  parameter int unsigned BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       serial_out
);

  localparam int unsigned SYMBOL_EDGE_TIME    = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME);
  localparam int unsigned CNT_W = (CLOCK_COUNTER_WIDTH > 0) ? CLOCK_COUNTER_WIDTH : 1;
  localparam int unsigned BIT_IDX_W = 3;

  // Last counter value of an ordinary bit period.
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(SYMBOL_EDGE_TIME - 1);
  // STOP exits one tick early; the last stop-bit cycle is the IDLE cycle.
  localparam logic [CNT_W-1:0] STOP_LAST_TICK = CNT_W'(SYMBOL_EDGE_TIME - 2);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(7);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [7:0]           shift_q, shift_d;
  logic                 serial_d;
  logic                 ready_d;
  logic                 tick_last;
  logic                 stop_last;
  logic                 accept;

  assign tick_last = (cnt_q == LAST_TICK);
  assign stop_last = (cnt_q == STOP_LAST_TICK);
  assign accept    = data_in_valid && data_in_ready;

  // State, counters, shift register and both outputs live in one flop bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      serial_out    <= 1'b1;
      data_in_ready <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      serial_out    <= serial_d;
      data_in_ready <= ready_d;
    end
  end

  // Next-state and next-output logic. serial_d is the level for the coming bit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    serial_d  = serial_out;
    ready_d   = data_in_ready;

    case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        ready_d  = 1'b1;
        cnt_d    = '0;
        if (accept) begin
          state_d   = START;
          shift_d   = data_in;
          bit_idx_d = '0;
          serial_d  = 1'b0;
          ready_d   = 1'b0;
        end
      end

      START: begin
        serial_d = 1'b0;
        ready_d  = 1'b0;
        cnt_d    = cnt_q + CNT_W'(1);
        if (tick_last) begin
          state_d   = DATA;
          cnt_d     = '0;
          bit_idx_d = '0;
          serial_d  = shift_q[0];
        end
      end

      DATA: begin
        ready_d = 1'b0;
        cnt_d   = cnt_q + CNT_W'(1);
        if (tick_last) begin
          cnt_d = '0;
          if (bit_idx_q == LAST_BIT) begin
            state_d  = STOP;
            serial_d = 1'b1;
          end else begin
            // Shift right so the next data bit is always at position 0.
            bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
            shift_d   = {1'b0, shift_q[7:1]};
            serial_d  = shift_q[1];
          end
        end
      end

      STOP: begin
        serial_d = 1'b1;
        ready_d  = 1'b0;
        cnt_d    = cnt_q + CNT_W'(1);
        if (stop_last) begin
          state_d = IDLE;
          cnt_d   = '0;
          ready_d = 1'b1;
        end
      end

      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        serial_d = 1'b1;
        ready_d  = 1'b1;
      end
    endcase
  end

endmodule
